// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the sequential code prefetcher.
package prefetch_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, GAP} state_t;

    localparam int DWORD_BYTES = 4;

    function automatic logic [31:0] dword_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/prefetch_if.sv
// Memory controller read port seen by the prefetcher (master) and controller (slave).
interface prefetch_if;
    logic        bus_read_vaild;
    logic        bus_read_ready;
    logic [31:0] bus_read_address;
    logic [31:0] bus_read_data;

    modport master (
        output bus_read_vaild,
        output bus_read_address,
        input  bus_read_ready,
        input  bus_read_data
    );

    modport slave (
        input  bus_read_vaild,
        input  bus_read_address,
        output bus_read_ready,
        output bus_read_data
    );
endinterface

// File: rtl/prefetch_queue.sv
// Dword FIFO holding fetched code; head is always visible, clear empties it in one cycle.
module prefetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [31:0]              push_data,
    output logic [31:0]              head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][31:0] mem;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/prefetch_unit.sv
// Sequential code prefetcher: dword reads from the memory controller, bytes out to the decoder.
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH  = 4,
    parameter int          MIN_LATENCY  = 2,
    parameter logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_address,
    prefetch_if.master  bus,
    output logic        queue_valid,
    output logic [7:0]  queue_data,
    input  logic        queue_ready
);
    localparam int CW  = $clog2(QUEUE_DEPTH) + 1;
    localparam int WCW = $clog2(MIN_LATENCY + 2);

    state_t         state, state_nx;
    logic           vld_q, vld_nx;
    logic [31:0]    addr_q, addr_nx;
    logic [31:0]    fetch_q, fetch_nx;
    logic [1:0]     skip_q, skip_nx;
    logic [1:0]     offset_q, offset_nx;
    logic [WCW-1:0] wait_q, wait_nx;

    logic           push, pop, clear;
    logic [31:0]    head;
    logic [CW-1:0]  count;
    logic           completion, can_issue, consume;

    prefetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data (bus.bus_read_data),
        .head      (head),
        .count     (count)
    );

    assign bus.bus_read_vaild   = vld_q;
    assign bus.bus_read_address = addr_q;
    assign queue_valid          = (count != '0);
    assign queue_data           = head[8*offset_q +: 8];

    assign completion = bus.bus_read_ready && (wait_q >= WCW'(MIN_LATENCY));
    assign can_issue  = (count < CW'(QUEUE_DEPTH));
    assign consume    = queue_valid && queue_ready && !flush;

    always_comb begin
        state_nx  = state;
        vld_nx    = vld_q;
        addr_nx   = addr_q;
        fetch_nx  = fetch_q;
        skip_nx   = skip_q;
        offset_nx = offset_q;
        wait_nx   = (wait_q >= WCW'(MIN_LATENCY)) ? wait_q : wait_q + 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;

        unique case (state)
            // GAP shares the issue check with IDLE so valid drops for a single cycle.
            IDLE, GAP: begin
                if (!flush && can_issue) begin
                    state_nx = REQ;
                    vld_nx   = 1'b1;
                    addr_nx  = fetch_q;
                    wait_nx  = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            REQ: begin
                if (flush) begin
                    state_nx = DISCARD;
                end else if (completion) begin
                    push     = 1'b1;
                    fetch_nx = fetch_q + 32'(DWORD_BYTES);
                    vld_nx   = 1'b0;
                    state_nx = GAP;
                end
            end
            DISCARD: begin
                if (!flush && completion) begin
                    vld_nx   = 1'b0;
                    state_nx = GAP;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (consume) begin
            if (offset_q == 2'd3) begin
                pop       = 1'b1;
                offset_nx = 2'd0;
            end else begin
                offset_nx = offset_q + 2'd1;
            end
        end

        // skip only applies to the first dword after a redirect; later pushes start at byte 0.
        if (push) begin
            skip_nx = 2'd0;
            if (count == '0)
                offset_nx = skip_q;
        end

        if (flush) begin
            clear     = 1'b1;
            offset_nx = 2'd0;
            fetch_nx  = dword_align(flush_address);
            skip_nx   = flush_address[1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            vld_q    <= 1'b0;
            addr_q   <= '0;
            fetch_q  <= dword_align(RESET_VECTOR);
            skip_q   <= RESET_VECTOR[1:0];
            offset_q <= '0;
            wait_q   <= '0;
        end else begin
            state    <= state_nx;
            vld_q    <= vld_nx;
            addr_q   <= addr_nx;
            fetch_q  <= fetch_nx;
            skip_q   <= skip_nx;
            offset_q <= offset_nx;
            wait_q   <= wait_nx;
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: fetch order, latency, gap, full stall, wrap, flush, reset.
module tb_prefetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_address;
    logic        queue_valid;
    logic [7:0]  queue_data;
    logic        queue_ready;

    int nassert = 0;
    int nfail   = 0;

    prefetch_if bus ();

    prefetch_unit #(
        .QUEUE_DEPTH  (4),
        .MIN_LATENCY  (2),
        .RESET_VECTOR (32'hFFFF_FFF0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .flush_address (flush_address),
        .bus           (bus),
        .queue_valid   (queue_valid),
        .queue_data    (queue_data),
        .queue_ready   (queue_ready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request with ready held high: valid holds for the latency, then completes.
    task automatic do_req(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        bus.bus_read_data = data;
        chk({tag, "_vld"},  32'(bus.bus_read_vaild), 32'd1);
        chk({tag, "_addr"}, bus.bus_read_address, exp_addr);
        tick();
        chk({tag, "_hold1"}, 32'(bus.bus_read_vaild), 32'd1);
        chk({tag, "_stable"}, bus.bus_read_address, exp_addr);
        tick();
        chk({tag, "_hold2"}, 32'(bus.bus_read_vaild), 32'd1);
        tick();
        chk({tag, "_done"}, 32'(bus.bus_read_vaild), 32'd0);
        tick();
    endtask

    initial begin
        reset              = 1'b0;
        flush              = 1'b0;
        flush_address      = '0;
        queue_ready        = 1'b0;
        bus.bus_read_ready = 1'b0;
        bus.bus_read_data  = '0;
        tick();
        tick();

        chk("rst_vld",   32'(bus.bus_read_vaild), 32'd0);
        chk("rst_addr",  bus.bus_read_address, 32'h0);
        chk("rst_qv",    32'(queue_valid), 32'd0);
        chk("rst_qdata", 32'(queue_data), 32'h0);

        // First fetch: ready arrives early but latency must still be honoured.
        reset = 1'b1;
        tick();
        chk("t1_vld",  32'(bus.bus_read_vaild), 32'd1);
        chk("t1_addr", bus.bus_read_address, 32'hFFFF_FFF0);
        tick();
        bus.bus_read_ready = 1'b1;
        bus.bus_read_data  = 32'h4433_2211;
        tick();
        chk("t1_lat_hold", 32'(bus.bus_read_vaild), 32'd1);
        tick();
        chk("t1_done_vld", 32'(bus.bus_read_vaild), 32'd0);
        chk("t1_qv",       32'(queue_valid), 32'd1);
        chk("t1_b0",       32'(queue_data), 32'h11);
        bus.bus_read_ready = 1'b0;
        queue_ready        = 1'b1;
        tick();
        chk("t1_b1",        32'(queue_data), 32'h22);
        chk("t1_next_vld",  32'(bus.bus_read_vaild), 32'd1);
        chk("t1_next_addr", bus.bus_read_address, 32'hFFFF_FFF4);
        tick();
        chk("t1_b2", 32'(queue_data), 32'h33);
        tick();
        chk("t1_b3", 32'(queue_data), 32'h44);
        tick();
        chk("t1_empty", 32'(queue_valid), 32'd0);

        // Reset in the middle of the outstanding request to FFFF_FFF4.
        queue_ready = 1'b0;
        reset       = 1'b0;
        tick();
        chk("rst_req_vld", 32'(bus.bus_read_vaild), 32'd0);
        chk("rst_req_qv",  32'(queue_valid), 32'd0);
        reset              = 1'b1;
        bus.bus_read_ready = 1'b1;
        tick();

        // Sticky ready, no consumption: four requests fill the queue, then issue stops.
        do_req("f0", 32'hFFFF_FFF0, 32'h0302_0100);
        do_req("f4", 32'hFFFF_FFF4, 32'h0706_0504);
        do_req("f8", 32'hFFFF_FFF8, 32'h0B0A_0908);
        do_req("fc", 32'hFFFF_FFFC, 32'h0F0E_0D0C);
        chk("full_vld",   32'(bus.bus_read_vaild), 32'd0);
        chk("full_qv",    32'(queue_valid), 32'd1);
        chk("full_qdata", 32'(queue_data), 32'h00);
        tick();
        chk("full_stall", 32'(bus.bus_read_vaild), 32'd0);

        queue_ready = 1'b1;
        tick();
        chk("drain_b1", 32'(queue_data), 32'h01);
        tick();
        chk("drain_b2", 32'(queue_data), 32'h02);
        tick();
        chk("drain_b3", 32'(queue_data), 32'h03);
        tick();
        chk("pop_next_dword", 32'(queue_data), 32'h04);
        chk("pop_no_issue",   32'(bus.bus_read_vaild), 32'd0);
        queue_ready = 1'b0;
        tick();
        chk("wrap_vld",  32'(bus.bus_read_vaild), 32'd1);
        chk("wrap_addr", bus.bus_read_address, 32'h0000_0000);

        // Flush to an unaligned target while the wrap request is in flight.
        flush             = 1'b1;
        flush_address     = 32'h0000_1003;
        bus.bus_read_data = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0;
        chk("fl_qv",   32'(queue_valid), 32'd0);
        chk("fl_vld",  32'(bus.bus_read_vaild), 32'd1);
        chk("fl_addr", bus.bus_read_address, 32'h0000_0000);
        tick();
        chk("disc_hold", 32'(bus.bus_read_vaild), 32'd1);
        tick();
        chk("disc_done", 32'(bus.bus_read_vaild), 32'd0);
        chk("disc_qv",   32'(queue_valid), 32'd0);
        tick();
        do_req("redir", 32'h0000_1000, 32'hA3A2_A1A0);
        chk("redir_qv",   32'(queue_valid), 32'd1);
        chk("redir_skip", 32'(queue_data), 32'hA3);
        chk("next_addr",  bus.bus_read_address, 32'h0000_1004);

        // Flush coinciding with a completion and a consume: neither takes effect.
        tick();
        tick();
        flush             = 1'b1;
        flush_address     = 32'h0000_2000;
        queue_ready       = 1'b1;
        bus.bus_read_data = 32'hB3B2_B1B0;
        tick();
        flush             = 1'b0;
        queue_ready       = 1'b0;
        bus.bus_read_data = 32'hC3C2_C1C0;
        chk("flcomp_qv", 32'(queue_valid), 32'd0);
        tick();
        chk("flcomp_disc", 32'(bus.bus_read_vaild), 32'd0);
        chk("flcomp_qv2",  32'(queue_valid), 32'd0);
        tick();
        do_req("fl2", 32'h0000_2000, 32'hC3C2_C1C0);
        chk("fl2_qv", 32'(queue_valid), 32'd1);
        chk("fl2_b0", 32'(queue_data), 32'hC0);
        queue_ready = 1'b1;
        tick();
        chk("fl2_b1", 32'(queue_data), 32'hC1);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
